// File: rtl/async_fifo_gen2_if.sv
// Producer/consumer handshake bundle for the dual-clock FIFO.
`timescale 1ns/1ps
interface async_fifo_gen2_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic                wen;
  logic [DATA_W-1:0]   wdata;
  logic                wfull;
  logic                walmost_full;
  logic [ADDR_W:0]     wlevel;
  logic                woverflow;
  logic                ren;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDR_W:0]     rlevel;
  logic                runderflow;

  modport master (
    output wen, wdata, ren,
    input  wfull, walmost_full, wlevel, woverflow,
    input  rdata, rvalid, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  wen, wdata, ren,
    output wfull, walmost_full, wlevel, woverflow,
    output rdata, rvalid, rempty, ralmost_empty, rlevel, runderflow
  );
endinterface

// File: rtl/async_fifo_gen2.sv
// Dual-clock FIFO with Gray-coded pointer crossing, registered flags/levels,
// sticky overflow/underflow and a registered read port.
`timescale 1ns/1ps
module async_fifo_gen2 #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AFULL_TH    = 14,
  parameter int unsigned AEMPTY_TH   = 2
) (
  input  logic                wclk,
  input  logic                rclk,
  input  logic                rrst_n,
  async_fifo_gen2_if.slave    f
);
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b = g;
    for (int i = 1; i < PTR_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

  // Per-domain reset: asserts asynchronously, releases after SYNC_STAGES local edges
  logic [SYNC_STAGES-1:0] wrst_sync, rrst_sync;
  logic                   wrst_n, rrst_n_s;

  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) wrst_sync <= '0;
    else         wrst_sync <= {wrst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rrst_sync <= '0;
    else         rrst_sync <= {rrst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign wrst_n   = wrst_sync[SYNC_STAGES-1];
  assign rrst_n_s = rrst_sync[SYNC_STAGES-1];

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PTR_W-1:0] wbin_q, wgray_q, wlevel_q;
  logic [PTR_W-1:0] wbin_nxt, wgray_nxt, wlevel_nxt, w_rgray_s;
  logic [PTR_W-1:0] w_rq [SYNC_STAGES];
  logic             wfull_q, walmost_q, woverflow_q;
  logic             wfull_nxt, walmost_nxt, w_push;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) w_rq[i] <= '0;
    end else begin
      w_rq[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) w_rq[i] <= w_rq[i-1];
    end
  end

  assign w_rgray_s = w_rq[SYNC_STAGES-1];

  // Full when the next write pointer sits exactly one lap ahead of the synced read pointer
  always_comb begin
    w_push      = f.wen & ~wfull_q & wrst_n;
    wbin_nxt    = wbin_q + PTR_W'(w_push);
    wgray_nxt   = wbin_nxt ^ (wbin_nxt >> 1);
    wfull_nxt   = (wgray_nxt == {~w_rgray_s[PTR_W-1:PTR_W-2], w_rgray_s[PTR_W-3:0]});
    wlevel_nxt  = wbin_nxt - gray2bin(w_rgray_s);
    walmost_nxt = (wlevel_nxt >= PTR_W'(AFULL_TH));
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      wfull_q     <= 1'b0;
      walmost_q   <= 1'b0;
      wlevel_q    <= '0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_nxt;
      wgray_q     <= wgray_nxt;
      wfull_q     <= wfull_nxt;
      walmost_q   <= walmost_nxt;
      wlevel_q    <= wlevel_nxt;
      woverflow_q <= woverflow_q | (f.wen & wfull_q);
    end
  end

  always_ff @(posedge wclk) begin
    if (w_push) mem[wbin_q[ADDR_W-1:0]] <= f.wdata;
  end

  // ---------------- read domain ----------------
  logic [PTR_W-1:0]  rbin_q, rgray_q, rlevel_q;
  logic [PTR_W-1:0]  rbin_nxt, rgray_nxt, rlevel_nxt, r_wgray_s;
  logic [PTR_W-1:0]  r_wq [SYNC_STAGES];
  logic              rempty_q, raempty_q, runderflow_q, rvalid_q;
  logic              rempty_nxt, raempty_nxt, r_pop;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge rclk or negedge rrst_n_s) begin
    if (!rrst_n_s) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_wq[i] <= '0;
    end else begin
      r_wq[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) r_wq[i] <= r_wq[i-1];
    end
  end

  assign r_wgray_s = r_wq[SYNC_STAGES-1];

  always_comb begin
    r_pop       = f.ren & ~rempty_q & rrst_n_s;
    rbin_nxt    = rbin_q + PTR_W'(r_pop);
    rgray_nxt   = rbin_nxt ^ (rbin_nxt >> 1);
    rempty_nxt  = (rgray_nxt == r_wgray_s);
    rlevel_nxt  = gray2bin(r_wgray_s) - rbin_nxt;
    raempty_nxt = (rlevel_nxt <= PTR_W'(AEMPTY_TH));
  end

  always_ff @(posedge rclk or negedge rrst_n_s) begin
    if (!rrst_n_s) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rbin_q       <= rbin_nxt;
      rgray_q      <= rgray_nxt;
      rempty_q     <= rempty_nxt;
      raempty_q    <= raempty_nxt;
      rlevel_q     <= rlevel_nxt;
      runderflow_q <= runderflow_q | (f.ren & rempty_q);
      rvalid_q     <= r_pop;
      if (r_pop) rdata_q <= mem[rbin_q[ADDR_W-1:0]];
    end
  end

  assign f.wfull         = wfull_q;
  assign f.walmost_full  = walmost_q;
  assign f.wlevel        = wlevel_q;
  assign f.woverflow     = woverflow_q;
  assign f.rdata         = rdata_q;
  assign f.rvalid        = rvalid_q;
  assign f.rempty        = rempty_q;
  assign f.ralmost_empty = raempty_q;
  assign f.rlevel        = rlevel_q;
  assign f.runderflow    = runderflow_q;
endmodule

// File: tb/tb_async_fifo_gen2.sv
// Self-checking bench for async_fifo_gen2: vector tables, corner sequences and a queue-model stress run.
`timescale 1ns/1ps
module tb_async_fifo_gen2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SYNC   = 2;

  logic    wclk = 1'b0;
  logic    rclk = 1'b0;
  logic    rrst_n = 1'b0;
  realtime r_half = 15.0;
  int      n_tests = 0;
  int      n_fail  = 0;

  async_fifo_gen2_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) f ();

  async_fifo_gen2 #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .wclk(wclk), .rclk(rclk), .rrst_n(rrst_n), .f(f)
  );

  always #5 wclk = ~wclk;
  always #(r_half) rclk = ~rclk;

  typedef struct {
    logic       wen;
    logic [7:0] wdata;
    logic       exp_full;
    logic       exp_afull;
    logic [4:0] exp_level;
    logic       exp_ovf;
  } wvec_t;

  typedef struct {
    logic       ren;
    logic [7:0] exp_rdata;
    logic       exp_rvalid;
    logic       exp_empty;
    logic [4:0] exp_level;
    logic       exp_aempty;
    logic       exp_udf;
  } rvec_t;

  wvec_t      wv [17];
  rvec_t      rv [17];
  logic [7:0] model [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wtick();
    @(posedge wclk); #1;
  endtask

  task automatic rtick();
    @(posedge rclk); #1;
  endtask

  task automatic do_reset();
    f.wen  = 1'b0;
    f.ren  = 1'b0;
    rrst_n = 1'b0;
    repeat (3) @(posedge wclk);
    repeat (3) @(posedge rclk);
    rrst_n = 1'b1;
    repeat (SYNC + 2) wtick();
    repeat (SYNC + 2) rtick();
  endtask

  task automatic wait_not_empty(input string name, output int edges);
    edges = 0;
    while (f.rempty && edges < 20) begin
      rtick();
      edges++;
    end
    check(name, 32'(f.rempty), 32'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          edges;
    logic [31:0] lvl;

    f.wen = 1'b0; f.wdata = '0; f.ren = 1'b0;

    // Expected vectors derived from the occupancy rules
    for (int i = 0; i < 17; i++) begin
      lvl             = (i < 16) ? 32'(i + 1) : 32'd16;
      wv[i].wen       = 1'b1;
      wv[i].wdata     = (i < 16) ? 8'(i) : 8'hAA;
      wv[i].exp_level = 5'(lvl);
      wv[i].exp_full  = (lvl == 32'd16);
      wv[i].exp_afull = (lvl >= 32'd14);
      wv[i].exp_ovf   = (i == 16);
    end
    for (int i = 0; i < 17; i++) begin
      lvl              = (i < 16) ? 32'(15 - i) : 32'd0;
      rv[i].ren        = 1'b1;
      rv[i].exp_rdata  = (i < 16) ? 8'(i) : 8'h0F;
      rv[i].exp_rvalid = (i < 16);
      rv[i].exp_empty  = (i >= 15);
      rv[i].exp_level  = 5'(lvl);
      rv[i].exp_aempty = (lvl <= 32'd2);
      rv[i].exp_udf    = (i == 16);
    end

    // Reset state
    do_reset();
    check("reset rempty",        32'(f.rempty), 32'h1);
    check("reset wfull",         32'(f.wfull), 32'h0);
    check("reset rvalid",        32'(f.rvalid), 32'h0);
    check("reset rdata",         32'(f.rdata), 32'h0);
    check("reset wlevel",        32'(f.wlevel), 32'h0);
    check("reset rlevel",        32'(f.rlevel), 32'h0);
    check("reset woverflow",     32'(f.woverflow), 32'h0);
    check("reset runderflow",    32'(f.runderflow), 32'h0);
    check("reset walmost_full",  32'(f.walmost_full), 32'h0);
    check("reset ralmost_empty", 32'(f.ralmost_empty), 32'h1);

    // Fill past full
    wtick();
    for (int i = 0; i < 17; i++) begin
      f.wen   = wv[i].wen;
      f.wdata = wv[i].wdata;
      wtick();
      check($sformatf("fill[%0d] wfull", i),        32'(f.wfull), 32'(wv[i].exp_full));
      check($sformatf("fill[%0d] walmost_full", i), 32'(f.walmost_full), 32'(wv[i].exp_afull));
      check($sformatf("fill[%0d] wlevel", i),       32'(f.wlevel), 32'(wv[i].exp_level));
      check($sformatf("fill[%0d] woverflow", i),    32'(f.woverflow), 32'(wv[i].exp_ovf));
    end
    f.wen = 1'b0;

    // Drain past empty
    repeat (SYNC + 3) rtick();
    check("pre-drain rempty", 32'(f.rempty), 32'h0);
    check("pre-drain rlevel", 32'(f.rlevel), 32'd16);
    for (int i = 0; i < 17; i++) begin
      f.ren = rv[i].ren;
      rtick();
      check($sformatf("drain[%0d] rdata", i),         32'(f.rdata), 32'(rv[i].exp_rdata));
      check($sformatf("drain[%0d] rvalid", i),        32'(f.rvalid), 32'(rv[i].exp_rvalid));
      check($sformatf("drain[%0d] rempty", i),        32'(f.rempty), 32'(rv[i].exp_empty));
      check($sformatf("drain[%0d] rlevel", i),        32'(f.rlevel), 32'(rv[i].exp_level));
      check($sformatf("drain[%0d] ralmost_empty", i), 32'(f.ralmost_empty), 32'(rv[i].exp_aempty));
      check($sformatf("drain[%0d] runderflow", i),    32'(f.runderflow), 32'(rv[i].exp_udf));
    end
    f.ren = 1'b0;
    repeat (SYNC + 2) wtick();
    check("post-drain wfull",  32'(f.wfull), 32'h0);
    check("post-drain wlevel", 32'(f.wlevel), 32'h0);

    // Single-word latency
    do_reset();
    wtick();
    f.wen = 1'b1; f.wdata = 8'h5A;
    wtick();
    f.wen = 1'b0;
    wait_not_empty("latency rempty fall", edges);
    check("latency within bound", 32'(edges <= int'(SYNC + 2)), 32'h1);
    f.ren = 1'b1;
    rtick();
    f.ren = 1'b0;
    check("latency rvalid", 32'(f.rvalid), 32'h1);
    check("latency rdata",  32'(f.rdata), 32'h5A);
    rtick();
    check("latency rvalid drop", 32'(f.rvalid), 32'h0);
    check("latency rdata hold",  32'(f.rdata), 32'h5A);
    check("latency rempty",      32'(f.rempty), 32'h1);

    // Random stress against a queue model
    r_half = 13.5;
    repeat (4) rtick();
    model.delete();
    fork
      begin : writer
        int sent = 0;
        int guard = 0;
        wtick();
        while (sent < 100 && guard < 20000) begin
          f.wen = ($urandom_range(0, 2) != 0) && !f.wfull;
          if (f.wen) begin
            f.wdata = 8'($urandom);
            model.push_back(f.wdata);
            sent++;
          end
          wtick();
          guard++;
        end
        f.wen = 1'b0;
        check("stress words sent", 32'(sent), 32'd100);
      end
      begin : reader
        int   got = 0;
        int   guard = 0;
        logic popped;
        rtick();
        while (got < 100 && guard < 8000) begin
          f.ren  = ($urandom_range(0, 3) != 0) && !f.rempty;
          popped = f.ren;
          rtick();
          if (popped) begin
            check("stress rdata", 32'(f.rdata), (model.size() > 0) ? 32'(model.pop_front()) : 32'h100);
            check("stress rvalid", 32'(f.rvalid), 32'h1);
            got++;
          end else begin
            check("stress rvalid idle", 32'(f.rvalid), 32'h0);
          end
          guard++;
        end
        f.ren = 1'b0;
        check("stress words received", 32'(got), 32'd100);
      end
    join
    repeat (SYNC + 3) wtick();
    repeat (SYNC + 3) rtick();
    check("stress model drained", 32'(model.size()), 32'h0);
    check("stress woverflow",     32'(f.woverflow), 32'h0);
    check("stress runderflow",    32'(f.runderflow), 32'h0);
    check("stress rempty",        32'(f.rempty), 32'h1);
    check("stress wlevel",        32'(f.wlevel), 32'h0);
    check("stress rlevel",        32'(f.rlevel), 32'h0);

    // Reset in the middle of traffic
    wtick();
    for (int i = 0; i < 5; i++) begin
      f.wen = 1'b1; f.wdata = 8'(8'h10 + i);
      wtick();
    end
    f.wen = 1'b0;
    repeat (SYNC + 3) rtick();
    check("midreset rlevel before", 32'(f.rlevel), 32'd5);
    check("midreset wlevel before", 32'(f.wlevel), 32'd5);
    rrst_n = 1'b0;
    #1;
    check("midreset rempty",  32'(f.rempty), 32'h1);
    check("midreset rlevel",  32'(f.rlevel), 32'h0);
    check("midreset wlevel",  32'(f.wlevel), 32'h0);
    check("midreset wfull",   32'(f.wfull), 32'h0);
    check("midreset rdata",   32'(f.rdata), 32'h0);
    repeat (3) @(posedge wclk);
    repeat (3) @(posedge rclk);
    rrst_n = 1'b1;
    repeat (SYNC + 2) wtick();
    repeat (SYNC + 2) rtick();
    check("post-reset rempty", 32'(f.rempty), 32'h1);
    wtick();
    f.wen = 1'b1; f.wdata = 8'h77;
    wtick();
    f.wen = 1'b0;
    wait_not_empty("post-reset rempty fall", edges);
    f.ren = 1'b1;
    rtick();
    f.ren = 1'b0;
    check("post-reset rdata",  32'(f.rdata), 32'h77);
    check("post-reset rvalid", 32'(f.rvalid), 32'h1);
    check("post-reset drained", 32'(f.rempty), 32'h1);
    check("post-reset rlevel",  32'(f.rlevel), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
